// File: rtl/irq_dispatch.sv
// Interrupt arbiter/dispatcher: IME tracking with delayed EI, fixed-priority pick (bit 0 highest),
// vector generation, one-hot IF clear and HALT wake. Optional IRQ_CANCEL_EN re-arbitrates at dispatch_ack.
module irq_dispatch #(
  parameter int                NUM_IRQ    = 5,
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(16'h0040),
  parameter int                VEC_STRIDE = 8,
  localparam int               IDX_W      = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_flag,
  input  logic [NUM_IRQ-1:0] irq_enable,
  input  logic               insn_boundary,
  input  logic               ime_set,
  input  logic               ime_clr,
  input  logic               reti,
  input  logic               dispatch_ack,
  output logic               dispatch_req,
  output logic [ADDR_W-1:0]  dispatch_vec,
  output logic [IDX_W-1:0]   dispatch_idx,
  output logic               if_clr_valid,
  output logic [NUM_IRQ-1:0] if_clr_mask,
  output logic               ime,
  output logic               wake
);

  typedef enum logic [1:0] {IDLE, PENDING, COMMIT} state_t;

  function automatic logic [ADDR_W-1:0] vec_of(input logic [IDX_W-1:0] idx);
    return VEC_BASE + ADDR_W'(idx) * ADDR_W'(VEC_STRIDE);
  endfunction

  state_t             state_q, state_d;
  logic               ime_q, ime_d;
  logic               ei_pending_q, ei_pending_d;
  logic               req_q, req_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               clr_valid_q, clr_valid_d;
  logic [NUM_IRQ-1:0] clr_mask_q, clr_mask_d;
  logic               wake_q, wake_d;
`ifndef IRQ_CANCEL_EN
  logic [ADDR_W-1:0]  vec_q, vec_d;
`endif

  logic [NUM_IRQ-1:0] pend;
  logic               pend_any;
  logic [IDX_W-1:0]   win_idx;

  assign pend     = irq_flag & irq_enable;
  assign pend_any = |pend;

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    win_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i]) win_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    ime_d        = ime_q;
    ei_pending_d = ei_pending_q;
    req_d        = req_q;
    idx_d        = idx_q;
    clr_valid_d  = 1'b0;
    clr_mask_d   = '0;
    wake_d       = pend_any;
`ifndef IRQ_CANCEL_EN
    vec_d        = vec_q;
`endif

    if (ime_clr) begin
      ime_d        = 1'b0;
      ei_pending_d = 1'b0;
    end else begin
      if (reti) ime_d = 1'b1;
      // ime is still 0 at the promoting boundary, so no dispatch can start there.
      if (ei_pending_q && insn_boundary) begin
        ime_d        = 1'b1;
        ei_pending_d = 1'b0;
      end
      if (ime_set) ei_pending_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (insn_boundary && ime_q && pend_any && !ime_clr) begin
          state_d = PENDING;
          req_d   = 1'b1;
          idx_d   = win_idx;
`ifndef IRQ_CANCEL_EN
          vec_d   = vec_of(win_idx);
`endif
        end
      end
      PENDING: begin
        if (dispatch_ack) begin
          state_d      = COMMIT;
          req_d        = 1'b0;
          ime_d        = 1'b0;
          ei_pending_d = 1'b0;
          clr_valid_d  = 1'b1;
`ifdef IRQ_CANCEL_EN
          idx_d        = win_idx;
          clr_mask_d   = pend_any ? (NUM_IRQ'(1) << win_idx) : '0;
`else
          clr_mask_d   = NUM_IRQ'(1) << idx_q;
          vec_d        = '0;
`endif
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ime_q        <= 1'b0;
      ei_pending_q <= 1'b0;
      req_q        <= 1'b0;
      idx_q        <= '0;
      clr_valid_q  <= 1'b0;
      clr_mask_q   <= '0;
      wake_q       <= 1'b0;
`ifndef IRQ_CANCEL_EN
      vec_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ime_q        <= ime_d;
      ei_pending_q <= ei_pending_d;
      req_q        <= req_d;
      idx_q        <= idx_d;
      clr_valid_q  <= clr_valid_d;
      clr_mask_q   <= clr_mask_d;
      wake_q       <= wake_d;
`ifndef IRQ_CANCEL_EN
      vec_q        <= vec_d;
`endif
    end
  end

`ifdef IRQ_CANCEL_EN
  assign dispatch_vec = (state_q == PENDING && pend_any) ? vec_of(win_idx) : '0;
`else
  assign dispatch_vec = vec_q;
`endif
  assign dispatch_req = req_q;
  assign dispatch_idx = idx_q;
  assign if_clr_valid = clr_valid_q;
  assign if_clr_mask  = clr_mask_q;
  assign ime          = ime_q;
  assign wake         = wake_q;

endmodule

// File: tb/tb_irq_dispatch.sv
// Bench for irq_dispatch: directed scenarios plus randomized traffic against a behavioural model.
module tb_irq_dispatch;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  irq_flag, irq_enable;
  logic        insn_boundary, ime_set, ime_clr, reti, dispatch_ack;
  logic        dispatch_req;
  logic [15:0] dispatch_vec;
  logic [2:0]  dispatch_idx;
  logic        if_clr_valid;
  logic [4:0]  if_clr_mask;
  logic        ime, wake;

  int total = 0;
  int bad   = 0;

  irq_dispatch dut (
    .clk(clk), .rst(rst), .irq_flag(irq_flag), .irq_enable(irq_enable),
    .insn_boundary(insn_boundary), .ime_set(ime_set), .ime_clr(ime_clr), .reti(reti),
    .dispatch_ack(dispatch_ack), .dispatch_req(dispatch_req), .dispatch_vec(dispatch_vec),
    .dispatch_idx(dispatch_idx), .if_clr_valid(if_clr_valid), .if_clr_mask(if_clr_mask),
    .ime(ime), .wake(wake)
  );

  always #5 clk = ~clk;

`ifdef IRQ_CANCEL_EN
  localparam bit CANCEL = 1'b1;
`else
  localparam bit CANCEL = 1'b0;
`endif

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    insn_boundary = 0; ime_set = 0; ime_clr = 0; reti = 0; dispatch_ack = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    irq_flag = 0; irq_enable = 0;
    rst = 1; cyc(); rst = 0;
  endtask

  task automatic pulse_reti();
    reti = 1; cyc(); reti = 0;
  endtask

  // ---------------- behavioural model ----------------
  bit       m_ime, m_ei_armed, m_outstanding, m_strobe, m_wake;
  int       m_idx, m_vec_idx;
  bit [4:0] m_mask;

  function automatic int first_pending(input logic [4:0] p);
    for (int i = 0; i < 5; i++) if (p[i]) return i;
    return -1;
  endfunction

  function automatic logic [15:0] vector_for(input int line);
    return 16'((32'h40 + line * 8) % 65536);
  endfunction

  task automatic model_reset();
    m_ime = 0; m_ei_armed = 0; m_outstanding = 0; m_strobe = 0; m_wake = 0;
    m_idx = 0; m_vec_idx = -1; m_mask = 0;
  endtask

  // Advance the model across one clock edge using the currently driven inputs.
  task automatic model_step();
    int  w;
    bit  was_strobe;
    bit  nxt_ime, nxt_armed;
    w = first_pending(irq_flag & irq_enable);
    was_strobe = m_strobe;
    m_strobe = 0;
    m_mask = 0;
    m_wake = (w >= 0);
    nxt_ime = m_ime; nxt_armed = m_ei_armed;
    if (ime_clr) begin
      nxt_ime = 0; nxt_armed = 0;
    end else begin
      if (reti) nxt_ime = 1;
      if (m_ei_armed && insn_boundary) begin nxt_ime = 1; nxt_armed = 0; end
      if (ime_set) nxt_armed = 1;
    end
    if (was_strobe) begin
      // one quiet cycle after a commit
    end else if (m_outstanding) begin
      if (dispatch_ack) begin
        m_outstanding = 0; nxt_ime = 0; nxt_armed = 0; m_strobe = 1;
        if (CANCEL) begin
          m_idx  = (w >= 0) ? w : 0;
          m_mask = (w >= 0) ? 5'(1 << w) : 5'd0;
        end else begin
          m_mask = 5'(1 << m_idx);
        end
        m_vec_idx = -1;
      end
    end else if (insn_boundary && m_ime && w >= 0 && !ime_clr) begin
      m_outstanding = 1; m_idx = w; m_vec_idx = w;
    end
    m_ime = nxt_ime; m_ei_armed = nxt_armed;
  endtask

  function automatic logic [15:0] model_vec();
    int w;
    if (!m_outstanding) return 16'h0;
    if (!CANCEL) return vector_for(m_vec_idx);
    w = first_pending(irq_flag & irq_enable);
    return (w >= 0) ? vector_for(w) : 16'h0;
  endfunction

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    irq_flag = 5'b11111; irq_enable = 5'b11111; reti = 1; insn_boundary = 1;
    rst = 1; cyc(); cyc(); rst = 0; clear_inputs();
    total++; if (dispatch_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", dispatch_req); end
    total++; if (dispatch_vec !== 16'h0) begin bad++; $display("FAIL reset_vec got=%h exp=0000", dispatch_vec); end
    total++; if (dispatch_idx !== 3'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", dispatch_idx); end
    total++; if (if_clr_valid !== 1'b0) begin bad++; $display("FAIL reset_clr_valid got=%b exp=0", if_clr_valid); end
    total++; if (if_clr_mask !== 5'b0) begin bad++; $display("FAIL reset_mask got=%b exp=00000", if_clr_mask); end
    total++; if (ime !== 1'b0) begin bad++; $display("FAIL reset_ime got=%b exp=0", ime); end
    total++; if (wake !== 1'b0) begin bad++; $display("FAIL reset_wake got=%b exp=0", wake); end
  endtask

  task automatic test_priority();
    do_reset();
    pulse_reti();
    total++; if (ime !== 1'b1) begin bad++; $display("FAIL reti_ime got=%b exp=1", ime); end
    irq_flag = 5'b00101; irq_enable = 5'b11111; insn_boundary = 1; cyc(); insn_boundary = 0;
    total++; if (dispatch_req !== 1'b1) begin bad++; $display("FAIL prio_req got=%b exp=1", dispatch_req); end
    total++; if (dispatch_idx !== 3'd0) begin bad++; $display("FAIL prio_idx got=%0d exp=0", dispatch_idx); end
    total++; if (dispatch_vec !== 16'h0040) begin bad++; $display("FAIL prio_vec got=%h exp=0040", dispatch_vec); end
    insn_boundary = 1; cyc(); insn_boundary = 0;
    total++; if (dispatch_req !== 1'b1 || dispatch_vec !== 16'h0040) begin bad++; $display("FAIL prio_hold req=%b vec=%h exp=1/0040", dispatch_req, dispatch_vec); end
    dispatch_ack = 1; cyc(); dispatch_ack = 0;
    total++; if (ime !== 1'b0) begin bad++; $display("FAIL ack_ime got=%b exp=0", ime); end
    total++; if (dispatch_req !== 1'b0) begin bad++; $display("FAIL ack_req got=%b exp=0", dispatch_req); end
    total++; if (if_clr_valid !== 1'b1 || if_clr_mask !== 5'b00001) begin bad++; $display("FAIL ack_clr valid=%b mask=%b exp=1/00001", if_clr_valid, if_clr_mask); end
    cyc();
    total++; if (if_clr_valid !== 1'b0) begin bad++; $display("FAIL clr_pulse_len got=%b exp=0", if_clr_valid); end
  endtask

  task automatic test_high_line();
    do_reset();
    pulse_reti();
    irq_flag = 5'b10000; irq_enable = 5'b10000; insn_boundary = 1; cyc(); insn_boundary = 0;
    total++; if (dispatch_vec !== 16'h0060 || dispatch_idx !== 3'd4) begin bad++; $display("FAIL line4_vec vec=%h idx=%0d exp=0060/4", dispatch_vec, dispatch_idx); end
    dispatch_ack = 1; cyc(); dispatch_ack = 0;
    total++; if (if_clr_mask !== 5'b10000) begin bad++; $display("FAIL line4_mask got=%b exp=10000", if_clr_mask); end
    reti = 1; insn_boundary = 1; cyc(); clear_inputs();
    total++; if (dispatch_req !== 1'b0) begin bad++; $display("FAIL commit_ignores_boundary got=%b exp=0", dispatch_req); end
    insn_boundary = 1; cyc(); insn_boundary = 0;
    total++; if (dispatch_req !== 1'b1) begin bad++; $display("FAIL idle_after_commit got=%b exp=1", dispatch_req); end
    dispatch_ack = 1; cyc(); dispatch_ack = 0; cyc();
  endtask

  task automatic test_ei_delay();
    do_reset();
    irq_flag = 5'b00100; irq_enable = 5'b00100;
    ime_set = 1; cyc(); ime_set = 0;
    total++; if (ime !== 1'b0) begin bad++; $display("FAIL ei_not_immediate got=%b exp=0", ime); end
    insn_boundary = 1; cyc(); insn_boundary = 0;
    total++; if (ime !== 1'b1 || dispatch_req !== 1'b0) begin bad++; $display("FAIL ei_boundary ime=%b req=%b exp=1/0", ime, dispatch_req); end
    cyc();
    insn_boundary = 1; cyc(); insn_boundary = 0;
    total++; if (dispatch_req !== 1'b1 || dispatch_vec !== 16'h0050) begin bad++; $display("FAIL ei_dispatch req=%b vec=%h exp=1/0050", dispatch_req, dispatch_vec); end
    dispatch_ack = 1; cyc(); dispatch_ack = 0; cyc();
  endtask

  task automatic test_ime_ctrl();
    do_reset();
    pulse_reti();
    ime_set = 1; ime_clr = 1; cyc(); clear_inputs();
    total++; if (ime !== 1'b0) begin bad++; $display("FAIL set_clr_ime got=%b exp=0", ime); end
    insn_boundary = 1; cyc(); insn_boundary = 0;
    total++; if (ime !== 1'b0) begin bad++; $display("FAIL ei_cancelled got=%b exp=0", ime); end
    reti = 1; ime_clr = 1; cyc(); clear_inputs();
    total++; if (ime !== 1'b0) begin bad++; $display("FAIL reti_clr got=%b exp=0", ime); end
    pulse_reti();
    total++; if (ime !== 1'b1) begin bad++; $display("FAIL reti_alone got=%b exp=1", ime); end
    irq_flag = 5'b00001; irq_enable = 5'b00001; insn_boundary = 1; ime_clr = 1; cyc(); clear_inputs();
    total++; if (dispatch_req !== 1'b0 || ime !== 1'b0) begin bad++; $display("FAIL clr_blocks_dispatch req=%b ime=%b exp=0/0", dispatch_req, ime); end
  endtask

  task automatic test_wake_no_ime();
    do_reset();
    irq_flag = 5'b00010; irq_enable = 5'b00010;
    total++; if (wake !== 1'b0) begin bad++; $display("FAIL wake_early got=%b exp=0", wake); end
    cyc();
    total++; if (wake !== 1'b1) begin bad++; $display("FAIL wake_set got=%b exp=1", wake); end
    for (int i = 0; i < 10; i++) begin
      insn_boundary = 1; cyc(); insn_boundary = 0; cyc();
      total++; if (dispatch_req !== 1'b0) begin bad++; $display("FAIL no_ime_req[%0d] got=%b exp=0", i, dispatch_req); end
    end
    irq_enable = 0; cyc();
    total++; if (wake !== 1'b0) begin bad++; $display("FAIL wake_clear got=%b exp=0", wake); end
  endtask

  task automatic test_cancel();
    logic [15:0] exp_vec;
    logic [4:0]  exp_mask;
    do_reset();
    pulse_reti();
    irq_flag = 5'b00010; irq_enable = 5'b00010; insn_boundary = 1; cyc(); insn_boundary = 0;
    total++; if (dispatch_req !== 1'b1 || dispatch_idx !== 3'd1 || dispatch_vec !== 16'h0048) begin bad++; $display("FAIL c_req req=%b idx=%0d vec=%h exp=1/1/0048", dispatch_req, dispatch_idx, dispatch_vec); end
    irq_enable = 5'b0; ime_clr = 1; cyc(); ime_clr = 0;
    exp_vec = CANCEL ? 16'h0000 : 16'h0048;
    total++; if (dispatch_req !== 1'b1 || dispatch_vec !== exp_vec) begin bad++; $display("FAIL c_hold req=%b vec=%h exp=1/%h", dispatch_req, dispatch_vec, exp_vec); end
    dispatch_ack = 1; cyc(); dispatch_ack = 0;
    exp_mask = CANCEL ? 5'b00000 : 5'b00010;
    total++; if (if_clr_valid !== 1'b1 || if_clr_mask !== exp_mask || ime !== 1'b0) begin bad++; $display("FAIL c_ack valid=%b mask=%b ime=%b exp=1/%b/0", if_clr_valid, if_clr_mask, ime, exp_mask); end
    cyc();
    pulse_reti();
    irq_enable = 5'b00010; insn_boundary = 1; cyc(); insn_boundary = 0;
    total++; if (dispatch_req !== 1'b1) begin bad++; $display("FAIL c_req2 got=%b exp=1", dispatch_req); end
    rst = 1; cyc(); rst = 0;
    total++; if ({dispatch_req, dispatch_vec, dispatch_idx, if_clr_valid, if_clr_mask, ime, wake} !== '0) begin bad++; $display("FAIL mid_reset req=%b vec=%h idx=%0d clr=%b mask=%b ime=%b wake=%b exp=all0", dispatch_req, dispatch_vec, dispatch_idx, if_clr_valid, if_clr_mask, ime, wake); end
  endtask

  task automatic test_random();
    logic [15:0] ev;
    do_reset();
    model_reset();
    for (int n = 0; n < 600; n++) begin
      irq_flag      = 5'($urandom) & 5'($urandom);
      irq_enable    = 5'($urandom) | 5'($urandom);
      insn_boundary = ($urandom_range(0, 9) < 4);
      ime_set       = ($urandom_range(0, 9) == 0);
      ime_clr       = ($urandom_range(0, 19) == 0);
      reti          = ($urandom_range(0, 9) < 2);
      dispatch_ack  = ($urandom_range(0, 9) < 3);
      rst           = ($urandom_range(0, 99) == 0);
      if (rst) model_reset(); else model_step();
      cyc();
      ev = model_vec();
      total++; if (dispatch_req !== m_outstanding) begin bad++; $display("FAIL rnd_req[%0d] got=%b exp=%b", n, dispatch_req, m_outstanding); end
      total++; if (dispatch_vec !== ev) begin bad++; $display("FAIL rnd_vec[%0d] got=%h exp=%h", n, dispatch_vec, ev); end
      total++; if (dispatch_idx !== 3'(m_idx)) begin bad++; $display("FAIL rnd_idx[%0d] got=%0d exp=%0d", n, dispatch_idx, m_idx); end
      total++; if (if_clr_valid !== m_strobe || if_clr_mask !== m_mask) begin bad++; $display("FAIL rnd_clr[%0d] valid=%b mask=%b exp=%b/%b", n, if_clr_valid, if_clr_mask, m_strobe, m_mask); end
      total++; if (ime !== m_ime) begin bad++; $display("FAIL rnd_ime[%0d] got=%b exp=%b", n, ime, m_ime); end
      total++; if (wake !== m_wake) begin bad++; $display("FAIL rnd_wake[%0d] got=%b exp=%b", n, wake, m_wake); end
    end
    rst = 0; clear_inputs();
  endtask

  initial begin
    rst = 1; irq_flag = 0; irq_enable = 0; clear_inputs();
    test_reset();
    test_priority();
    test_high_line();
    test_ei_delay();
    test_ime_ctrl();
    test_wake_no_ime();
    test_cancel();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
